// File: rtl/adder_pipe_n_pkg.sv
// adder_pipe_n_pkg: default geometry of the multiplier's final adder and the segment-width rule
package adder_pipe_n_pkg;
  localparam int DEF_W = 32;
  localparam int DEF_BOFF = 2;
  localparam int DEF_STAGES = 4;
  function automatic int seg_width(input int w, input int stages);
    return w / stages;
  endfunction
endpackage

// File: rtl/adder_pipe_n_seg.sv
// adder_seg: N-bit carry-propagate segment with carry in and carry out
module adder_seg #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + (N+1)'(ci);
endmodule

// File: rtl/adder_pipe_n.sv
// adder_pipe_n: final Wallace-row adder, carry chain split into STAGES registered segments with valid/ready
module adder_pipe_n
  import adder_pipe_n_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int BOFF = DEF_BOFF,
  parameter int STAGES = DEF_STAGES
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-BOFF-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_sum,
  output logic            out_cout
);
  localparam int SEG = seg_width(W, STAGES);
  logic [W-1:0] b_shift;
  logic [STAGES-1:0] v, adv;
  assign b_shift = W'(in_b) << BOFF;
  assign in_ready = adv[0];
  for (genvar k = 0; k < STAGES; k++) begin : stg
    // R = operand bits still to be added when entering stage k
    localparam int R = W - k * SEG;
    logic [R-1:0] a_i, b_i;
    logic c_i, v_i, seg_c, v_r, c_r;
    logic [SEG-1:0] seg_s;
    logic [(k+1)*SEG-1:0] s_n, s_r;
    if (k == 0) begin : src
      assign a_i = in_a;
      assign b_i = b_shift;
      assign c_i = 1'b0;
      assign v_i = in_valid;
      assign s_n = seg_s;
    end else begin : src
      assign a_i = stg[k-1].rem.a_r;
      assign b_i = stg[k-1].rem.b_r;
      assign c_i = stg[k-1].c_r;
      assign v_i = stg[k-1].v_r;
      assign s_n = {seg_s, stg[k-1].s_r};
    end
    // a stage may move whenever any stage at or after it is empty, or the sink accepts
    assign adv[k] = out_ready | ~&v[STAGES-1:k];
    assign v[k] = v_r;
    adder_seg #(.N(SEG)) u_seg (
      .a(a_i[SEG-1:0]),
      .b(b_i[SEG-1:0]),
      .ci(c_i),
      .s(seg_s),
      .co(seg_c)
    );
    always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (adv[k]) begin
        v_r <= v_i;
        if (v_i) begin
          c_r <= seg_c;
          s_r <= s_n;
        end
      end
    if (k < STAGES - 1) begin : rem
      logic [R-SEG-1:0] a_r, b_r;
      always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (adv[k] && v_i) begin
          a_r <= a_i[R-1:SEG];
          b_r <= b_i[R-1:SEG];
        end
    end
  end
  assign out_valid = stg[STAGES-1].v_r;
  assign out_sum = stg[STAGES-1].s_r;
  assign out_cout = stg[STAGES-1].c_r;
endmodule

// File: tb/tb_adder_pipe_n.sv
// tb_adder_pipe_n: random and directed checks of two adder configurations against an arithmetic model
module tb_adder_pipe_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic av, ar, aov, aor, ac;
  logic [31:0] aa, as;
  logic [29:0] ab;
  logic bv, br, bov, bor, bc;
  logic [15:0] ba, bb, bs;
  int checks = 0;
  int failures = 0;
  logic [32:0] a_exp[$], a_got[$];
  logic [16:0] b_exp[$], b_got[$];
  bit a_hist[$];

  adder_pipe_n #(.W(32), .BOFF(2), .STAGES(4)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(av), .in_ready(ar), .in_a(aa), .in_b(ab),
    .out_valid(aov), .out_ready(aor), .out_sum(as), .out_cout(ac)
  );
  adder_pipe_n #(.W(16), .BOFF(0), .STAGES(2)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(bv), .in_ready(br), .in_a(ba), .in_b(bb),
    .out_valid(bov), .out_ready(bor), .out_sum(bs), .out_cout(bc)
  );

  // one clock: record transfers seen before the edge, then step past the edge
  task automatic tick();
    @(negedge clk);
    if (av && ar) a_exp.push_back(33'(aa) + (33'(ab) << 2));
    if (aov && aor) a_got.push_back({ac, as});
    a_hist.push_back(aov);
    if (bv && br) b_exp.push_back(17'(ba) + 17'(bb));
    if (bov && bor) b_got.push_back({bc, bs});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    a_exp.delete(); a_got.delete(); a_hist.delete(); b_exp.delete(); b_got.delete();
  endtask

  task automatic drain();
    av = 0; bv = 0; aor = 1; bor = 1;
    for (int i = 0; i < 200 && (a_got.size() != a_exp.size() || b_got.size() != b_exp.size()); i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({aov, as, ac} !== 34'd0) begin failures++; $display("FAIL reset_a out got v=%b sum=%h c=%b want 0", aov, as, ac); end
    checks++;
    if ({bov, bs, bc} !== 18'd0) begin failures++; $display("FAIL reset_b out got v=%b sum=%h c=%b want 0", bov, bs, bc); end
    checks++;
    if (ar !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", ar); end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] ta[2] = '{32'hFFFF_FFFF, 32'h8000_0000};
    logic [29:0] tb[2] = '{30'h1, 30'h2000_0000};
    logic [31:0] ts[2] = '{32'h3, 32'h0};
    int lat;
    for (int i = 0; i < 2; i++) begin
      clear_q();
      aor = 1; av = 1; aa = ta[i]; ab = tb[i];
      tick();
      av = 0;
      lat = 0;
      while (!aov && lat < 20) begin tick(); lat++; end
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL directed%0d_latency got %0d want 3", i, lat); end
      checks++;
      if (as !== ts[i]) begin failures++; $display("FAIL directed%0d_sum got %h want %h", i, as, ts[i]); end
      checks++;
      if (ac !== 1'b1) begin failures++; $display("FAIL directed%0d_cout got %b want 1", i, ac); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int first = -1, last = -1, ones = 0;
    clear_q();
    aor = 1;
    for (int i = 0; i < 3; i++) begin av = 1; aa = $urandom; ab = 30'($urandom); tick(); end
    av = 0;
    repeat (8) tick();
    for (int i = 0; i < a_hist.size(); i++) if (a_hist[i]) begin
      if (first < 0) first = i;
      last = i; ones++;
    end
    checks++;
    if (ones != 3 || last - first != 2) begin failures++; $display("FAIL b2b_contiguous got ones=%0d span=%0d want 3/2", ones, last - first); end
    checks++;
    if (a_got.size() != 3 || a_exp.size() != 3) begin failures++; $display("FAIL b2b_count got %0d/%0d want 3", a_got.size(), a_exp.size()); end
    for (int i = 0; i < 3 && i < a_got.size() && i < a_exp.size(); i++) begin
      checks++;
      if (a_got[i] !== a_exp[i]) begin failures++; $display("FAIL b2b_result%0d got %h want %h", i, a_got[i], a_exp[i]); end
    end
  endtask

  task automatic test_stall();
    logic [32:0] snap;
    bit stable = 1;
    clear_q();
    aor = 0;
    for (int i = 0; i < 8; i++) begin av = 1; aa = $urandom; ab = 30'($urandom); tick(); end
    av = 0;
    checks++;
    if (a_exp.size() != 4) begin failures++; $display("FAIL stall_accepts got %0d want 4", a_exp.size()); end
    checks++;
    if (ar !== 1'b0) begin failures++; $display("FAIL stall_in_ready got %b want 0", ar); end
    snap = {ac, as};
    repeat (10) begin tick(); if ({ac, as} !== snap || !aov) stable = 0; end
    checks++;
    if (!stable) begin failures++; $display("FAIL stall_hold got %h want %h", {ac, as}, snap); end
    drain();
    checks++;
    if (a_got.size() != 4) begin failures++; $display("FAIL stall_drain_count got %0d want 4", a_got.size()); end
    for (int i = 0; i < a_got.size() && i < a_exp.size(); i++) begin
      checks++;
      if (a_got[i] !== a_exp[i]) begin failures++; $display("FAIL stall_result%0d got %h want %h", i, a_got[i], a_exp[i]); end
    end
  endtask

  task automatic test_reset_flight();
    int n = 0;
    clear_q();
    aor = 0;
    for (int i = 0; i < 2; i++) begin av = 1; aa = $urandom; ab = 30'($urandom); tick(); end
    av = 0;
    while (!aov && n < 10) begin tick(); n++; end
    checks++;
    if (aov !== 1'b1) begin failures++; $display("FAIL flight_reached got %b want 1", aov); end
    #1 rst_n = 0;
    #1;
    checks++;
    if ({aov, as, ac} !== 34'd0) begin failures++; $display("FAIL flight_async_clear got v=%b sum=%h want 0", aov, as); end
    @(negedge clk);
    rst_n = 1;
    clear_q();
    aor = 1;
    repeat (10) tick();
    checks++;
    if (a_got.size() != 0) begin failures++; $display("FAIL flight_ghost got %0d outputs want 0", a_got.size()); end
  endtask

  task automatic test_random_a();
    int cyc = 0;
    clear_q();
    while (a_exp.size() < 10000 && cyc < 40000) begin
      av = $urandom_range(0, 3) != 0;
      aa = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      ab = ($urandom_range(0, 15) == 0) ? 30'h3FFF_FFFF : 30'($urandom);
      aor = $urandom_range(0, 3) != 0;
      tick(); cyc++;
    end
    drain();
    checks++;
    if (a_got.size() != a_exp.size() || a_exp.size() != 10000) begin failures++; $display("FAIL rand_a_count got %0d want %0d of 10000", a_got.size(), a_exp.size()); end
    for (int i = 0; i < a_got.size() && i < a_exp.size(); i++) begin
      checks++;
      if (a_got[i] !== a_exp[i]) begin failures++; $display("FAIL rand_a_result%0d got %h want %h", i, a_got[i], a_exp[i]); end
    end
  endtask

  task automatic test_random_b();
    int cyc = 0;
    clear_q();
    while (b_exp.size() < 10000 && cyc < 40000) begin
      bv = $urandom_range(0, 3) != 0;
      ba = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      bb = 16'($urandom);
      bor = $urandom_range(0, 3) != 0;
      tick(); cyc++;
    end
    drain();
    checks++;
    if (b_got.size() != b_exp.size() || b_exp.size() != 10000) begin failures++; $display("FAIL rand_b_count got %0d want %0d of 10000", b_got.size(), b_exp.size()); end
    for (int i = 0; i < b_got.size() && i < b_exp.size(); i++) begin
      checks++;
      if (b_got[i] !== b_exp[i]) begin failures++; $display("FAIL rand_b_result%0d got %h want %h", i, b_got[i], b_exp[i]); end
    end
  endtask

  initial begin
    av = 0; aa = '0; ab = '0; aor = 0;
    bv = 0; ba = '0; bb = '0; bor = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    test_random_a();
    test_random_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
